// File: rtl/alu_issue_stage_pkg.sv
// Shared widths, register-file geometry and opcode values for the ALU issue slice.
package alu_issue_stage_pkg;

  localparam int DEF_WORD_SIZE   = 16;
  localparam int DEF_OPCODE_SIZE = 4;
  localparam int REG_COUNT       = 8;
  localparam int REG_ADDR_W      = $clog2(REG_COUNT);

  // Opcodes the ALU implements; any other value passes through and yields 0.
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_ADD = 4'd0;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_SUB = 4'd1;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_AND = 4'd2;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_OR  = 4'd3;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_XOR = 4'd4;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_SHL = 4'd5;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_SHR = 4'd6;

endpackage

// File: rtl/alu_issue_stage_reg_file.sv
// Register file: two async read ports plus a debug read port, one sync write port.
// R0 is hardwired to zero; writes addressed to it are dropped.
module reg_file
  import alu_issue_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WORD_SIZE,
  parameter int DEPTH = REG_COUNT,
  parameter int AW    = REG_ADDR_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data2,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] regs [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: IDLE->ISSUE->CAPTURE, one instruction per 3 cycles; ALU samples at accept+1, write-back at accept+2.
// instr_ready is high only in IDLE, so an upstream holding instr_valid simply waits.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int WORD_SIZE   = DEF_WORD_SIZE,
  parameter int OPCODE_SIZE = DEF_OPCODE_SIZE
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic [REG_ADDR_W-1:0]  rd,
  input  logic [REG_ADDR_W-1:0]  rs1,
  input  logic [REG_ADDR_W-1:0]  rs2,
  input  logic [WORD_SIZE-1:0]   imm,
  input  logic                   use_imm,
  output logic [OPCODE_SIZE-1:0] alu_opcode,
  output logic [WORD_SIZE-1:0]   alu_input1,
  output logic [WORD_SIZE-1:0]   alu_input2,
  output logic                   alu_enable,
  input  logic [WORD_SIZE-1:0]   alu_out,
  output logic                   wb_valid,
  output logic [REG_ADDR_W-1:0]  wb_rd,
  output logic [WORD_SIZE-1:0]   wb_data,
  input  logic [REG_ADDR_W-1:0]  dbg_addr,
  output logic [WORD_SIZE-1:0]   dbg_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                 state;
  logic [REG_ADDR_W-1:0]  rd_q;
  logic [WORD_SIZE-1:0]   rs1_data;
  logic [WORD_SIZE-1:0]   rs2_data;
  logic                   accept;

  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid && instr_ready;

  // alu_enable and wb_valid are registered alongside the state so each is a
  // clean one-cycle pulse; the 3-cycle cadence guarantees a low gap between enables.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rd_q       <= '0;
      alu_opcode <= '0;
      alu_input1 <= '0;
      alu_input2 <= '0;
      alu_enable <= 1'b0;
      wb_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= ISSUE;
            rd_q       <= rd;
            alu_opcode <= opcode;
            alu_input1 <= rs1_data;
            alu_input2 <= use_imm ? imm : rs2_data;
            alu_enable <= 1'b1;
          end
        end
        ISSUE: begin
          state      <= CAPTURE;
          alu_enable <= 1'b0;
          wb_valid   <= 1'b1;
        end
        CAPTURE: begin
          state    <= IDLE;
          wb_valid <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          alu_enable <= 1'b0;
          wb_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign wb_rd   = wb_valid ? rd_q    : '0;
  assign wb_data = wb_valid ? alu_out : '0;

  reg_file #(
    .WIDTH (WORD_SIZE),
    .DEPTH (REG_COUNT),
    .AW    (REG_ADDR_W)
  ) u_reg_file (
    .clock    (clock),
    .reset    (reset),
    .rd_addr1 (rs1),
    .rd_data1 (rs1_data),
    .rd_addr2 (rs2),
    .rd_data2 (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_en    (wb_valid),
    .wr_addr  (rd_q),
    .wr_data  (alu_out)
  );

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomised bench for alu_issue_stage with a stub ALU and an architectural register model.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  localparam int W  = DEF_WORD_SIZE;
  localparam int OW = DEF_OPCODE_SIZE;

  logic          clock = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [OW-1:0] opcode;
  logic [2:0]    rd, rs1, rs2;
  logic [W-1:0]  imm;
  logic          use_imm;
  logic [OW-1:0] alu_opcode;
  logic [W-1:0]  alu_input1, alu_input2;
  logic          alu_enable;
  logic [W-1:0]  alu_out;
  logic          wb_valid;
  logic [2:0]    wb_rd;
  logic [W-1:0]  wb_data;
  logic [2:0]    dbg_addr;
  logic [W-1:0]  dbg_data;

  logic [W-1:0]  ref_r [8];
  int checks = 0;
  int errors = 0;

  alu_issue_stage dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .imm         (imm),
    .use_imm     (use_imm),
    .alu_opcode  (alu_opcode),
    .alu_input1  (alu_input1),
    .alu_input2  (alu_input2),
    .alu_enable  (alu_enable),
    .alu_out     (alu_out),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #10 clock = ~clock;

  function automatic logic [W-1:0] alu_fn(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << b[3:0];
      OP_SHR:  return a >> b[3:0];
      default: return '0;
    endcase
  endfunction

  // Stub ALU: registered result, updated only on cycles where enable is high.
  always @(posedge clock or posedge reset) begin
    if (reset) alu_out <= '0;
    else if (alu_enable) alu_out <= alu_fn(alu_opcode, alu_input1, alu_input2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 chk($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(ref_r[i]));
    end
    @(negedge clock);
  endtask

  // Called in the low phase of an IDLE cycle; returns in the low phase of the next IDLE cycle.
  task automatic run_instr(input logic [OW-1:0] op, input logic [2:0] d, input logic [2:0] s1,
                           input logic [2:0] s2, input logic [W-1:0] im, input logic ui, input string tag);
    logic [W-1:0] a, b, res;
    a   = ref_r[s1];
    b   = ui ? im : ref_r[s2];
    res = alu_fn(op, a, b);
    chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
    instr_valid = 1'b1; opcode = op; rd = d; rs1 = s1; rs2 = s2; imm = im; use_imm = ui;
    @(negedge clock);
    instr_valid = 1'b0;
    opcode = $urandom; rs1 = $urandom; rs2 = $urandom; imm = $urandom;
    chk({tag, "_issue_en"},  32'(alu_enable),  32'd1);
    chk({tag, "_issue_rdy"}, 32'(instr_ready), 32'd0);
    chk({tag, "_issue_wb"},  32'(wb_valid),    32'd0);
    chk({tag, "_op"},        32'(alu_opcode),  32'(op));
    chk({tag, "_in1"},       32'(alu_input1),  32'(a));
    chk({tag, "_in2"},       32'(alu_input2),  32'(b));
    @(negedge clock);
    chk({tag, "_cap_en"},  32'(alu_enable), 32'd0);
    chk({tag, "_cap_wb"},  32'(wb_valid),   32'd1);
    chk({tag, "_wb_rd"},   32'(wb_rd),      32'(d));
    chk({tag, "_wb_data"}, 32'(wb_data),    32'(res));
    chk({tag, "_cap_in2"}, 32'(alu_input2), 32'(b));
    @(negedge clock);
    if (d != 3'd0) ref_r[d] = res;
    chk({tag, "_idle_wb"},  32'(wb_valid),    32'd0);
    chk({tag, "_idle_rdy"}, 32'(instr_ready), 32'd1);
    dbg_addr = d;
    #1 chk({tag, "_dbg"}, 32'(dbg_data), 32'(ref_r[d]));
  endtask

  initial begin
    int edges;
    logic prev_en;
    instr_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; use_imm = 1'b0;
    dbg_addr = '0;
    for (int i = 0; i < 8; i++) ref_r[i] = '0;

    reset = 1'b1;
    #2;
    chk("rst_ready",  32'(instr_ready), 32'd1);
    chk("rst_enable", 32'(alu_enable),  32'd0);
    chk("rst_wb",     32'(wb_valid),    32'd0);
    check_regs("rst");
    reset = 1'b0;

    run_instr(OP_ADD, 3'd1, 3'd0, 3'd0, 16'h0005, 1'b1, "addi_r1");
    run_instr(OP_ADD, 3'd2, 3'd0, 3'd0, 16'h0003, 1'b1, "addi_r2");
    run_instr(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b0, "add_r3");
    dbg_addr = 3'd3;
    #1 chk("r3_is_8", 32'(dbg_data), 32'h0008);

    run_instr(OP_ADD, 3'd1, 3'd0, 3'd0, 16'hFFFF, 1'b1, "addi_ffff");
    run_instr(OP_ADD, 3'd1, 3'd1, 3'd0, 16'h0001, 1'b1, "addi_wrap");
    dbg_addr = 3'd1;
    #1 chk("r1_wrap", 32'(dbg_data), 32'h0000);

    run_instr(OP_ADD, 3'd0, 3'd0, 3'd0, 16'h1234, 1'b1, "addi_r0");
    dbg_addr = 3'd0;
    #1 chk("r0_zero", 32'(dbg_data), 32'h0000);

    run_instr(4'd12, 3'd6, 3'd0, 3'd0, 16'h5555, 1'b1, "unimpl");

    // Back-to-back: valid held high, three increments of r5.
    run_instr(OP_ADD, 3'd5, 3'd0, 3'd0, 16'($urandom), 1'b1, "seed_r5");
    instr_valid = 1'b1; opcode = OP_ADD; rd = 3'd5; rs1 = 3'd5; rs2 = 3'd0; imm = 16'h0001; use_imm = 1'b1;
    edges = 0;
    prev_en = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      if (k == 8) instr_valid = 1'b0;
      chk($sformatf("b2b_en%0d", k),  32'(alu_enable),  32'((k % 3) == 0));
      chk($sformatf("b2b_wb%0d", k),  32'(wb_valid),    32'((k % 3) == 1));
      chk($sformatf("b2b_rdy%0d", k), 32'(instr_ready), 32'((k % 3) == 2));
      if (alu_enable && !prev_en) edges++;
      prev_en = alu_enable;
    end
    chk("b2b_edges", 32'(edges), 32'd3);
    ref_r[5] = ref_r[5] + 16'd3;
    dbg_addr = 3'd5;
    #1 chk("b2b_r5", 32'(dbg_data), 32'(ref_r[5]));

    for (int n = 0; n < 40; n++) begin
      run_instr(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom),
                16'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
    end
    @(negedge clock);
    check_regs("mid");

    // Reset landing in CAPTURE must abandon the write-back.
    instr_valid = 1'b1; opcode = OP_ADD; rd = 3'd4; rs1 = 3'd0; rs2 = 3'd0; imm = 16'h00AA; use_imm = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    chk("rcap_wb_before", 32'(wb_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rcap_wb",    32'(wb_valid),    32'd0);
    chk("rcap_ready", 32'(instr_ready), 32'd1);
    chk("rcap_en",    32'(alu_enable),  32'd0);
    chk("rcap_op",    32'(alu_opcode),  32'd0);
    chk("rcap_in1",   32'(alu_input1),  32'd0);
    chk("rcap_in2",   32'(alu_input2),  32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) ref_r[i] = '0;
    check_regs("rcap");

    run_instr(OP_SUB, 3'd7, 3'd0, 3'd0, 16'h0001, 1'b1, "post_rst");
    for (int n = 0; n < 10; n++) begin
      run_instr(4'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
                16'($urandom), 1'($urandom), $sformatf("rnd2_%0d", n));
    end
    @(negedge clock);
    check_regs("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter WORD_SIZE, default 16, data word width; OPCODE_SIZE, default from shared parameters include, opcode width.
REQ-002 One clock; reset is asynchronous and active-high; ports named clock and reset.
REQ-003 clock  in  1  rising-edge clock shared with alu.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 instr_valid  in  1  decoded instruction present.
REQ-006 instr_ready  out  1  stage can accept an instruction.
REQ-007 opcode  in  OPCODE_SIZE  operation code, passed to ALU unmodified.
REQ-008 rd, rs1, rs2  in  3 each  destination and source register indices.
REQ-009 imm  in  WORD_SIZE  immediate operand.
REQ-010 use_imm  in  1  select imm instead of R[rs2] as second operand.
REQ-011 alu_opcode  out  OPCODE_SIZE  opcode to ALU.
REQ-012 alu_input1, alu_input2  out  WORD_SIZE each  ALU operands.
REQ-013 alu_enable  out  1  ALU enable pulse.
REQ-014 alu_out  in  WORD_SIZE  registered ALU result.
REQ-015 wb_valid  out  1  write-back occurring this cycle.
REQ-016 wb_rd  out  3  write-back register index; wb_data  out  WORD_SIZE  write-back value.
REQ-017 dbg_addr  in  3; dbg_data  out  WORD_SIZE  combinational register-file read port for test.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, CAPTURE; transitions IDLE->ISSUE on instr_valid&&instr_ready, ISSUE->CAPTURE unconditionally, CAPTURE->IDLE unconditionally.
REQ-019 instr_ready SHALL be 1 only in IDLE; instr_valid in other states is ignored.
REQ-020 On accept, stage SHALL register opcode, rd, alu_input1=R[rs1], alu_input2=use_imm?imm:R[rs2].
REQ-021 alu_enable SHALL be registered, 1 exactly during ISSUE, 0 otherwise; back-to-back instructions SHALL produce distinct rising edges (ALU gate counters count posedge enable).
REQ-022 alu_opcode/alu_input1/alu_input2 SHALL stay stable from ISSUE through CAPTURE.
REQ-023 In CAPTURE, wb_valid=1, wb_rd=latched rd, wb_data=alu_out; R[rd] SHALL be written at the CAPTURE->IDLE edge.
REQ-024 Register file: 8 x WORD_SIZE; R0 reads 0 always; writes with rd=0 SHALL be discarded while wb_valid still pulses.
REQ-025 Latency: accept edge T, ALU samples at T+1, write at T+2; throughput one instruction per 3 cycles.
REQ-026 Read-after-write: an instruction accepted the cycle after CAPTURE SHALL see the new value (no bypass needed; write completes first).
REQ-027 Opcodes the ALU does not implement SHALL still traverse all states; written value is whatever alu_out presents (0 by ALU default).
REQ-028 wb_valid SHALL be 0 outside CAPTURE; wb_rd/wb_data don't-care then but driven deterministically.

Reset
REQ-029 reset SHALL force IDLE, all registers R0-R7 to 0, alu_enable=0, alu_opcode/inputs=0, wb_valid=0 asynchronously.
REQ-030 Reset in ISSUE or CAPTURE SHALL abandon the instruction with no register write.
REQ-031 First accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-032 WORD_SIZE, OPCODE_SIZE, opcode macros, register count SHALL come from the shared parameters include; FSM state encodings local.
REQ-033 Register file SHALL be one sub-module, reg_file (2 async read ports + debug port, 1 sync write port, async reset).

Verification
REQ-034 After reset: dbg_data=0 for all addresses; instr_ready=1; alu_enable=0.
REQ-035 Load via ADDI r1,r0,imm=0x0005 then ADDI r2,r0,0x0003, ADD r3,r1,r2 -> R3=0x0008, wb_valid one cycle per instruction, wb_rd=3.
REQ-036 ADDI r1,r0,0xFFFF then ADDI r1,r1,0x0001 -> R1=0x0000 (wrap).
REQ-037 ADDI r0,r0,0x1234 -> wb_valid pulses, dbg_data(0)=0.
REQ-038 instr_valid held high continuously for 3 instructions -> accepts spaced exactly 3 cycles, 3 separate alu_enable pulses.
REQ-039 reset asserted during CAPTURE of ADDI r4,r0,0x00AA -> R4=0, state IDLE, wb_valid=0 immediately.
